// File: rtl/glip_jtag_data_transfer_if.sv
// Ingress/egress word handshake between the JTAG payload engine and the device side.
// The engine uses the master modport; the device logic uses the slave modport.
interface glip_jtag_data_transfer_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/glip_jtag_data_transfer.sv
// JTAG payload engine: one header word plus NUM_WORDS payload words per DR scan, LSB first.
// Scans are atomic; buffered ingress/egress words commit only on Update-DR after a full scan.
//
// state       | meaning
// IDLE        | device-side handshakes; first shift cycle snapshots counts and emits header bit 0
// HEADER      | header bits 1..W-1: tdo = {free, out count}, tdi = host word count
// PAYLOAD     | payload words: tdo from out_buf, tdi staged into in_buf
// WAIT_UPDATE | scan finished or discarded, waiting for Update-DR
module glip_jtag_data_transfer #(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_WORDS  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ctrl_logic_rst,
    input  logic data_transfer,
    input  logic shift,
    input  logic update,
    input  logic tdi,
    output logic tdo,
    output logic overflow,
    glip_jtag_data_transfer_if.master xfer
);
    localparam int HW = WORD_WIDTH / 2;
    localparam int CW = $clog2(NUM_WORDS + 1);
    localparam int BW = $clog2(WORD_WIDTH);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, WAIT_UPDATE} state_t;

    state_t state, state_next;

    logic [BW-1:0]         bit_cnt;
    logic [CW-1:0]         word_cnt, in_cnt, out_cnt, staged;
    logic [HW-1:0]         ocnt_s, free_s, host_cnt;
    logic [WORD_WIDTH-2:0] word_rx;
    logic                  complete, live;
    logic [WORD_WIDTH-1:0] in_buf  [NUM_WORDS];
    logic [WORD_WIDTH-1:0] out_buf [NUM_WORDS];
    logic [WORD_WIDTH-1:0] out_drop[NUM_WORDS];
    logic [WORD_WIDTH-1:0] tx_word, hdr_tx;
    logic [CW-1:0]         ocnt_next, in_next;
    logic                  push, pop, last_bit, last_word, first_bit, stage_ok;

    assign xfer.out_ready = live && (state == IDLE) && (out_cnt < CW'(NUM_WORDS));
    assign xfer.in_valid  = (state == IDLE) && (in_cnt != '0);
    assign xfer.in_data   = in_buf[0];

    assign push      = xfer.out_ready && xfer.out_valid;
    assign pop       = xfer.in_valid && xfer.in_ready;
    assign ocnt_next = out_cnt + CW'(push);
    assign in_next   = in_cnt - CW'(pop);
    assign hdr_tx    = {free_s, ocnt_s};
    assign last_bit  = (bit_cnt == BW'(WORD_WIDTH - 1));
    assign last_word = (word_cnt == CW'(NUM_WORDS - 1));
    assign first_bit = (word_cnt == '0) && (bit_cnt == '0);
    assign stage_ok  = (int'(word_cnt) < int'(host_cnt)) && (int'(word_cnt) < int'(free_s));

    always_comb begin
        tx_word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (k == int'(word_cnt)) tx_word = out_buf[k];
        end
    end

    // out_buf after removing the ocnt_s oldest entries that the host has just consumed
    always_comb begin
        for (int k = 0; k < NUM_WORDS; k++) begin
            out_drop[k] = '0;
            for (int j = 0; j < NUM_WORDS; j++) begin
                if (j == k + int'(ocnt_s)) out_drop[k] = out_buf[j];
            end
        end
    end

    always_comb begin
        tdo = 1'b0;
        case (state)
            IDLE:    tdo = shift & ocnt_next[0];
            HEADER:  tdo = hdr_tx[bit_cnt];
            PAYLOAD: tdo = data_transfer && (int'(word_cnt) < int'(ocnt_s)) && tx_word[bit_cnt];
            default: tdo = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (shift) state_next = HEADER;
            HEADER: begin
                if (update)                  state_next = IDLE;
                else if (shift && last_bit)  state_next = PAYLOAD;
            end
            PAYLOAD: begin
                if (update) state_next = IDLE;
                else if (shift) begin
                    if (first_bit && !data_transfer)  state_next = WAIT_UPDATE;
                    else if (last_bit && last_word)   state_next = WAIT_UPDATE;
                end
            end
            WAIT_UPDATE: if (update) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live     <= 1'b0;
            overflow <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            staged   <= '0;
            complete <= 1'b0;
            ocnt_s   <= '0;
            free_s   <= '0;
            host_cnt <= '0;
            word_rx  <= '0;
            for (int k = 0; k < NUM_WORDS; k++) begin
                in_buf[k]  <= '0;
                out_buf[k] <= '0;
            end
        end else begin
            live     <= 1'b1;
            overflow <= 1'b0;
            if (state == IDLE) begin
                if (push) begin
                    for (int k = 0; k < NUM_WORDS; k++) begin
                        if (k == int'(out_cnt)) out_buf[k] <= xfer.out_data;
                    end
                    out_cnt <= ocnt_next;
                end
                if (pop) begin
                    for (int k = 0; k < NUM_WORDS - 1; k++) in_buf[k] <= in_buf[k+1];
                    in_buf[NUM_WORDS-1] <= '0;
                    in_cnt <= in_next;
                end
                if (shift) begin
                    ocnt_s   <= HW'(ocnt_next);
                    free_s   <= HW'(CW'(NUM_WORDS) - in_next);
                    host_cnt <= {{(HW-1){1'b0}}, tdi};
                    bit_cnt  <= BW'(1);
                    word_cnt <= '0;
                    staged   <= '0;
                    complete <= 1'b0;
                end
            end else if (update) begin
                if (complete) begin
                    in_cnt   <= in_cnt + staged;
                    out_cnt  <= (out_cnt > CW'(ocnt_s)) ? out_cnt - CW'(ocnt_s) : '0;
                    overflow <= host_cnt > free_s;
                    for (int k = 0; k < NUM_WORDS; k++) out_buf[k] <= out_drop[k];
                end
                bit_cnt  <= '0;
                word_cnt <= '0;
                staged   <= '0;
                complete <= 1'b0;
            end else if (shift) begin
                if (state == HEADER) begin
                    for (int k = 0; k < HW; k++) begin
                        if (k == int'(bit_cnt)) host_cnt[k] <= tdi;
                    end
                    bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
                end else if (state == PAYLOAD && (data_transfer || !first_bit)) begin
                    for (int k = 0; k < WORD_WIDTH - 1; k++) begin
                        if (k == int'(bit_cnt)) word_rx[k] <= tdi;
                    end
                    bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
                    if (last_bit) begin
                        word_cnt <= word_cnt + CW'(1);
                        if (stage_ok) begin
                            for (int k = 0; k < NUM_WORDS; k++) begin
                                if (k == int'(in_cnt) + int'(staged)) in_buf[k] <= {tdi, word_rx};
                            end
                            staged <= staged + CW'(1);
                        end
                        if (last_word) complete <= 1'b1;
                    end
                end
            end
            if (ctrl_logic_rst) begin
                in_cnt  <= '0;
                out_cnt <= '0;
                staged  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_glip_jtag_data_transfer.sv
// Directed bench for glip_jtag_data_transfer with default parameters (16-bit words, 3 per scan).
module tb_glip_jtag_data_transfer;
    logic clk = 1'b0;
    logic rst_n, ctrl_logic_rst, data_transfer, shift, update, tdi;
    logic tdo, overflow;
    int   checks = 0;
    int   failures = 0;
    logic [15:0] hg;
    logic [15:0] wg;
    logic [47:0] pg;

    glip_jtag_data_transfer_if #(.WORD_WIDTH(16)) xfer_if ();

    glip_jtag_data_transfer #(.WORD_WIDTH(16), .NUM_WORDS(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ctrl_logic_rst (ctrl_logic_rst),
        .data_transfer  (data_transfer),
        .shift          (shift),
        .update         (update),
        .tdi            (tdi),
        .tdo            (tdo),
        .overflow       (overflow),
        .xfer           (xfer_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic shift_word(input logic [15:0] w, input int nbits, output logic [15:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            shift = 1'b1;
            tdi   = w[i];
            #1 got[i] = tdo;
        end
    endtask

    // Header, nwords payload words, then an Update-DR pulse; returns at the negedge after update.
    task automatic scan(input logic [15:0] hdr, input logic [47:0] pay, input int nwords,
                        output logic [15:0] hdr_got, output logic [47:0] pay_got);
        logic [15:0] w;
        shift_word(hdr, 16, hdr_got);
        pay_got = '0;
        for (int k = 0; k < nwords; k++) begin
            shift_word(pay[k*16 +: 16], 16, w);
            pay_got[k*16 +: 16] = w;
        end
        @(negedge clk);
        shift  = 1'b0;
        tdi    = 1'b0;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic push_out(input logic [15:0] w);
        @(negedge clk);
        xfer_if.out_valid = 1'b1;
        xfer_if.out_data  = w;
        @(negedge clk);
        xfer_if.out_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ctrl_logic_rst = 1'b0; data_transfer = 1'b1;
        shift = 1'b0; update = 1'b0; tdi = 1'b0;
        xfer_if.in_ready = 1'b0; xfer_if.out_valid = 1'b0; xfer_if.out_data = '0;
        repeat (2) @(negedge clk);
        check("rst_in_valid", xfer_if.in_valid, 0);
        check("rst_out_ready", xfer_if.out_ready, 0);
        check("rst_tdo", tdo, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_ready", xfer_if.out_ready, 1);

        // egress round trip
        push_out(16'h1111);
        push_out(16'h2222);
        scan(16'h0000, 48'h0, 3, hg, pg);
        check("t1_hdr", hg, 16'h0302);
        check("t1_w0", pg[15:0], 16'h1111);
        check("t1_w1", pg[31:16], 16'h2222);
        check("t1_w2", pg[47:32], 16'h0000);
        check("t1_out_ready", xfer_if.out_ready, 1);
        check("t1_in_valid", xfer_if.in_valid, 0);

        // ingress delivery
        xfer_if.in_ready = 1'b1;
        scan(16'h0002, {16'hCCCC, 16'hBBBB, 16'hAAAA}, 3, hg, pg);
        check("t2_hdr", hg, 16'h0300);
        check("t2_payload_tdo", pg, 48'h0);
        check("t2_valid0", xfer_if.in_valid, 1);
        check("t2_data0", xfer_if.in_data, 16'hAAAA);
        @(negedge clk);
        check("t2_valid1", xfer_if.in_valid, 1);
        check("t2_data1", xfer_if.in_data, 16'hBBBB);
        @(negedge clk);
        check("t2_drained", xfer_if.in_valid, 0);
        xfer_if.in_ready = 1'b0;

        // overflow with two words already waiting
        scan(16'h0002, {16'h9ABC, 16'h5678, 16'h1234}, 3, hg, pg);
        check("t3_fill_ovf", overflow, 0);
        scan(16'h0003, {16'hF00D, 16'hBEEF, 16'hDEAD}, 3, hg, pg);
        check("t3_hdr", hg, 16'h0100);
        check("t3_ovf_pulse", overflow, 1);
        check("t3_head", xfer_if.in_data, 16'h1234);
        xfer_if.in_ready = 1'b1;
        @(negedge clk);
        check("t3_ovf_clear", overflow, 0);
        check("t3_data1", xfer_if.in_data, 16'h5678);
        @(negedge clk);
        check("t3_data2", xfer_if.in_data, 16'hDEAD);
        check("t3_valid2", xfer_if.in_valid, 1);
        @(negedge clk);
        check("t3_drained", xfer_if.in_valid, 0);
        xfer_if.in_ready = 1'b0;

        // config scan leaves both sides alone
        push_out(16'h3333);
        push_out(16'h4444);
        data_transfer = 1'b0;
        scan(16'h0003, {16'h5555, 16'h6666, 16'h7777}, 3, hg, pg);
        check("t4_hdr", hg, 16'h0302);
        check("t4_payload_tdo", pg, 48'h0);
        check("t4_ovf", overflow, 0);
        check("t4_in_valid", xfer_if.in_valid, 0);
        data_transfer = 1'b1;

        // aborted scan after payload word 1, then a full scan re-sends the same words
        scan(16'h0003, {16'h0000, 16'h8888, 16'h9999}, 2, hg, pg);
        check("t5_abort_w0", pg[15:0], 16'h3333);
        check("t5_abort_w1", pg[31:16], 16'h4444);
        check("t5_abort_in_valid", xfer_if.in_valid, 0);
        check("t5_abort_ovf", overflow, 0);
        scan(16'h0000, 48'h0, 3, hg, pg);
        check("t5_hdr", hg, 16'h0302);
        check("t5_w0", pg[15:0], 16'h3333);
        check("t5_w1", pg[31:16], 16'h4444);
        check("t5_w2", pg[47:32], 16'h0000);

        // fill both buffers, then flush via ctrl_logic_rst
        scan(16'h0003, {16'h0303, 16'h0202, 16'h0101}, 3, hg, pg);
        check("t6_hdr", hg, 16'h0300);
        check("t6_fill_ovf", overflow, 0);
        check("t6_in_valid", xfer_if.in_valid, 1);
        check("t6_in_data", xfer_if.in_data, 16'h0101);
        push_out(16'h7001);
        push_out(16'h7002);
        push_out(16'h7003);
        check("t6_out_full", xfer_if.out_ready, 0);
        @(negedge clk);
        ctrl_logic_rst = 1'b1;
        @(negedge clk);
        ctrl_logic_rst = 1'b0;
        check("t6_flush_in_valid", xfer_if.in_valid, 0);
        check("t6_flush_out_ready", xfer_if.out_ready, 1);

        // asynchronous reset in the middle of payload word 0
        push_out(16'hF0F0);
        shift_word(16'h0000, 16, hg);
        check("t7_hdr", hg, 16'h0301);
        shift_word(16'h0000, 6, wg);
        check("t7_partial", wg, 16'h0030);
        rst_n = 1'b0;
        shift = 1'b0;
        #1;
        check("t7_tdo", tdo, 0);
        check("t7_in_valid", xfer_if.in_valid, 0);
        check("t7_out_ready", xfer_if.out_ready, 0);
        check("t7_overflow", overflow, 0);
        check("t7_in_data", xfer_if.in_data, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t7_recover_out_ready", xfer_if.out_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
